// File: rtl/if_id_fetch_stage.sv
// if_id_fetch_stage: program counter, synchronous IMEM drive and IF/ID boundary
// register for the stall/flush pipeline protocol.
// A one-entry skid buffer keeps the in-flight IMEM word alive across a stall.
// Optional feature macro: IF_PERF_CNT_EN enables the stall/flush cycle counters.
module if_id_fetch_stage #(
    parameter int                        REG_DATA_WIDTH = 32,
    parameter logic [REG_DATA_WIDTH-1:0] PC_RESET       = 32'h0000_0000,
    parameter logic [REG_DATA_WIDTH-1:0] NOP_INSTR      = 32'h0000_0013
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      Stall,
    input  logic                      IF_ID_Flush,
    input  logic                      PC_load,
    input  logic [REG_DATA_WIDTH-1:0] PC_target,
    output logic [REG_DATA_WIDTH-1:0] IMEM_addr,
    output logic                      IMEM_rd_en,
    input  logic [REG_DATA_WIDTH-1:0] IMEM_rdata,
    output logic [REG_DATA_WIDTH-1:0] IF_Instruction,
    output logic [REG_DATA_WIDTH-1:0] ID_Instruction,
    output logic [REG_DATA_WIDTH-1:0] ID_PC,
    output logic                      ID_Valid,
    output logic [31:0]               Perf_stall_cnt,
    output logic [31:0]               Perf_flush_cnt
);

    typedef enum logic {RUN, HOLD} state_e;

    state_e                    state_q, state_d;
    logic [REG_DATA_WIDTH-1:0] pc_q, pc_d;
    logic [REG_DATA_WIDTH-1:0] fetch_pc_q;
    logic                      fetch_valid_q;
    logic [REG_DATA_WIDTH-1:0] skid_instr_q, skid_pc_q;
    logic                      skid_valid_q;
    logic [REG_DATA_WIDTH-1:0] id_instr_q, id_pc_q;
    logic                      id_valid_q;

    // Source of the instruction waiting to enter ID (live IMEM word or skid).
    logic [REG_DATA_WIDTH-1:0] src_instr, src_pc;
    logic                      src_valid;

    assign IMEM_addr      = pc_q;
    assign IMEM_rd_en     = !Reset;
    assign IF_Instruction = src_instr;
    assign ID_Instruction = id_instr_q;
    assign ID_PC          = id_pc_q;
    assign ID_Valid       = id_valid_q;

    // Next PC: redirect beats stall beats sequential increment (wraps naturally).
    always_comb begin
        pc_d = pc_q + REG_DATA_WIDTH'(4);
        if (PC_load) begin
            pc_d = {PC_target[REG_DATA_WIDTH-1:2], 2'b00};
        end else if (Stall) begin
            pc_d = pc_q;
        end
    end

    // PC register.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // pre-edge values regardless of block ordering.
        if (Reset) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Track which PC the IMEM word arriving next cycle belongs to, and whether it is
    // on the correct path.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fetch_pc_q    <= PC_RESET;
            fetch_valid_q <= 1'b0;
        end else begin
            fetch_valid_q <= !(PC_load || IF_ID_Flush);
            if (!Stall) begin
                fetch_pc_q <= pc_q;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: flush always returns to RUN; stall parks in HOLD.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d = state_q;
        if (IF_ID_Flush) begin
            state_d = RUN;
        end else begin
            unique case (state_q)
                RUN:  if (Stall)  state_d = HOLD;
                HOLD: if (!Stall) state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    // FSM output: pick the live IMEM word in RUN, the parked word in HOLD.
    always_comb begin
        src_instr = IMEM_rdata;
        src_pc    = fetch_pc_q;
        src_valid = fetch_valid_q;
        if (state_q == HOLD) begin
            src_instr = skid_instr_q;
            src_pc    = skid_pc_q;
            src_valid = skid_valid_q;
        end
    end

    // Skid buffer: captured once on RUN->HOLD, untouched while held, emptied on flush.
    always_ff @(posedge Clk) begin
        if (Reset || IF_ID_Flush) begin
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= '0;
            skid_valid_q <= 1'b0;
        end else if (state_q == RUN && Stall) begin
            skid_instr_q <= IMEM_rdata;
            skid_pc_q    <= fetch_pc_q;
            skid_valid_q <= fetch_valid_q;
        end
    end

    // IF/ID register: flush inserts a bubble, stall holds, otherwise advance.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            id_instr_q <= NOP_INSTR;
            id_pc_q    <= '0;
            id_valid_q <= 1'b0;
        end else if (IF_ID_Flush) begin
            id_instr_q <= NOP_INSTR;
            id_valid_q <= 1'b0;
        end else if (!Stall) begin
            id_instr_q <= src_valid ? src_instr : NOP_INSTR;
            id_pc_q    <= src_pc;
            id_valid_q <= src_valid;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    // Saturating stall/flush cycle counters.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (Stall && stall_cnt_q != 32'hFFFF_FFFF) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (IF_ID_Flush && flush_cnt_q != 32'hFFFF_FFFF) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign Perf_stall_cnt = stall_cnt_q;
    assign Perf_flush_cnt = flush_cnt_q;
`else
    assign Perf_stall_cnt = 32'd0;
    assign Perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Bench for if_id_fetch_stage: directed scenarios pinned with literal values, then
// randomized stall/flush/redirect traffic compared against an instruction-slot model.
module tb_if_id_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, stall, flush, pc_load;
    logic [31:0] pc_target;
    logic [31:0] imem_addr, imem_rdata, if_instr, id_instr, id_pc;
    logic        imem_rd_en, id_valid;
    logic [31:0] perf_stall, perf_flush;

    int total_cnt = 0;
    int pass_cnt  = 0;

    // Model: PC, the single instruction waiting in IF (by address), and ID contents.
    logic [31:0] m_pc, m_slot_pc, m_id_instr, m_id_pc, m_stall_cnt, m_flush_cnt;
    logic        m_slot_v, m_id_v, m_rst;

    always #5 clk = ~clk;

    if_id_fetch_stage dut (
        .Clk(clk), .Reset(reset), .Stall(stall), .IF_ID_Flush(flush),
        .PC_load(pc_load), .PC_target(pc_target),
        .IMEM_addr(imem_addr), .IMEM_rd_en(imem_rd_en), .IMEM_rdata(imem_rdata),
        .IF_Instruction(if_instr), .ID_Instruction(id_instr), .ID_PC(id_pc),
        .ID_Valid(id_valid), .Perf_stall_cnt(perf_stall), .Perf_flush_cnt(perf_flush)
    );

    // Memory contents derived from the address so every word is distinct.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16] + 16'h0101};
    endfunction

    // Synchronous 1-cycle IMEM.
    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= mem_word(imem_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    endtask

    task automatic model_update(input logic rst, st, fl, ld, input logic [31:0] tgt);
        m_rst = rst;
        if (rst) begin
            m_pc = 32'h0; m_slot_pc = 32'h0; m_slot_v = 1'b0;
            m_id_instr = NOP; m_id_pc = 32'h0; m_id_v = 1'b0;
            m_stall_cnt = 32'h0; m_flush_cnt = 32'h0;
        end else begin
            if (st && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
            if (fl && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt++;
            if (fl) begin
                m_id_instr = NOP; m_id_v = 1'b0;
                m_slot_v = 1'b0;
            end else if (!st) begin
                m_id_instr = m_slot_v ? mem_word(m_slot_pc) : NOP;
                m_id_pc    = m_slot_pc;
                m_id_v     = m_slot_v;
                m_slot_pc  = m_pc;
                m_slot_v   = !ld;
            end
            if (ld)       m_pc = tgt & 32'hFFFF_FFFC;
            else if (!st) m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic compare_all();
        check("imem_addr", imem_addr, m_pc);
        check("imem_rd_en", 32'(imem_rd_en), 32'(!m_rst));
        check("id_valid", 32'(id_valid), 32'(m_id_v));
        check("id_instr", id_instr, m_id_instr);
        if (m_id_v || m_rst) check("id_pc", id_pc, m_id_pc);
        if (m_slot_v && !m_rst) check("if_instr", if_instr, mem_word(m_slot_pc));
`ifdef IF_PERF_CNT_EN
        check("perf_stall", perf_stall, m_stall_cnt);
        check("perf_flush", perf_flush, m_flush_cnt);
`else
        check("perf_stall", perf_stall, 32'h0);
        check("perf_flush", perf_flush, 32'h0);
`endif
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare at negedge.
    task automatic step(input logic rst, st, fl, ld, input logic [31:0] tgt);
        reset = rst; stall = st; flush = fl; pc_load = ld; pc_target = tgt;
        @(posedge clk);
        model_update(rst, st, fl, ld, tgt);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        // Reset 3 cycles, release: addresses 0,4,8 and first valid ID at cycle 2.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        check("pin_reset_addr", imem_addr, 32'h0);
        check("pin_reset_valid", 32'(id_valid), 32'h0);
        check("pin_reset_instr", id_instr, NOP);
        step(0, 0, 0, 0, 0);
        check("pin_c1_addr", imem_addr, 32'h4);
        check("pin_c1_valid", 32'(id_valid), 32'h0);
        step(0, 0, 0, 0, 0);
        check("pin_c2_addr", imem_addr, 32'h8);
        check("pin_c2_idpc", id_pc, 32'h0);
        check("pin_c2_valid", 32'(id_valid), 32'h1);
        step(0, 0, 0, 0, 0);
        check("pin_c3_idpc", id_pc, 32'h4);

        // One-cycle stall with mem[8] in IF: ID sees 4, 8, 12 with no loss or repeat.
        step(0, 1, 0, 0, 0);
        check("pin_stall_if", if_instr, mem_word(32'h8));
        check("pin_stall_idpc", id_pc, 32'h4);
        step(0, 0, 0, 0, 0);
        check("pin_resume_idpc", id_pc, 32'h8);
        check("pin_resume_instr", id_instr, mem_word(32'h8));
        step(0, 0, 0, 0, 0);
        check("pin_next_idpc", id_pc, 32'hC);

        // Three-cycle stall: ID frozen, sequence resumes with the held instruction.
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0);
            check("pin_stall3_idpc", id_pc, 32'hC);
        end
        step(0, 0, 0, 0, 0);
        check("pin_stall3_resume", id_pc, 32'h10);
`ifdef IF_PERF_CNT_EN
        check("pin_perf_stall", perf_stall, 32'd4);
`endif

        // Redirect to 0x103 with flush: aligned fetch, two bubbles, then 0x100.
        step(0, 0, 1, 1, 32'h103);
        check("pin_redir_addr", imem_addr, 32'h100);
        check("pin_redir_v0", 32'(id_valid), 32'h0);
        step(0, 0, 0, 0, 0);
        check("pin_redir_v1", 32'(id_valid), 32'h0);
        step(0, 0, 0, 0, 0);
        check("pin_redir_idpc", id_pc, 32'h100);
        check("pin_redir_valid", 32'(id_valid), 32'h1);

        // Stall + flush while held: bubble, and normal flow afterwards.
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        check("pin_holdflush_valid", 32'(id_valid), 32'h0);
        check("pin_holdflush_instr", id_instr, NOP);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Reset in the middle of a hold.
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        check("pin_midhold_addr", imem_addr, 32'h0);
        check("pin_midhold_valid", 32'(id_valid), 32'h0);
        check("pin_midhold_perf", perf_stall, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic r, s, f, l;
            r = ($urandom_range(99) == 0);
            s = ($urandom_range(99) < 35);
            f = ($urandom_range(99) < 8);
            l = ($urandom_range(99) < 8);
            step(r, s, f, l, $urandom());
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
